// File: rtl/jtcontra_colmix_pkg.sv
// Shared types and constants for the jtcontra priority/colour mixer.
package jtcontra_colmix_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} fetch_st_t;

    localparam logic [3:0] TRANSP_MASK = 4'hF;

endpackage

// File: rtl/jtcontra_colmix_prio.sv
// Combinational winner select: lowest-numbered opaque layer, else layer 0 as backdrop.
module jtcontra_colmix_prio
    import jtcontra_colmix_pkg::*;
#(
    parameter int LAYERS = 2,
    parameter int PXLW   = 7,
    parameter int BLKBIT = 4
)(
    input  logic [LAYERS-1:0]      layer_en,
    input  logic [LAYERS*PXLW-1:0] gfx_pxl,
    output logic [PXLW-1:0]        win_pxl
);

    // Scan from the lowest priority upward so the last hit is the highest-priority layer.
    always_comb begin
        win_pxl = gfx_pxl[PXLW-1:0];
        for (int k = LAYERS-1; k >= 0; k--) begin
            if (layer_en[k] && ((gfx_pxl[k*PXLW +: 4] & TRANSP_MASK) != 4'd0) &&
                (k == 0 || !gfx_pxl[k*PXLW + BLKBIT]))
                win_pxl = gfx_pxl[k*PXLW +: PXLW];
        end
    end

endmodule

// File: rtl/jtframe_dual_ram.sv
// Byte-wide dual-port RAM with registered reads; port 0 read/write, port 1 read-only.
module jtframe_dual_ram #(
    parameter int dw = 8,
    parameter int aw = 8
)(
    input  logic          clk0,
    input  logic [dw-1:0] data0,
    input  logic [aw-1:0] addr0,
    input  logic          we0,
    output logic [dw-1:0] q0,
    input  logic          clk1,
    input  logic [aw-1:0] addr1,
    output logic [dw-1:0] q1
);

    logic [dw-1:0] mem [0:2**aw-1];

    // Reads sample the array before the same-edge write lands, so a collision returns old data.
    always_ff @(posedge clk0) begin
        q0 <= mem[addr0];
        if (we0) mem[addr0] <= data0;
    end

    always_ff @(posedge clk1) begin
        q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtcontra_prio_colmix.sv
// Multi-layer priority mixer with two-read palette fetch aligned to pxl_cen and output blanking.
module jtcontra_prio_colmix
    import jtcontra_colmix_pkg::*;
#(
    parameter int LAYERS   = 2,
    parameter int PXLW     = 7,
    parameter int BLKBIT   = 4,
    parameter int HI_FIRST = 1
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    input  logic                   pal_cs,
    input  logic                   cpu_rnw,
    input  logic                   cpu_cen,
    input  logic [PXLW:0]          cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    input  logic [LAYERS-1:0]      layer_en,
    input  logic [LAYERS*PXLW-1:0] gfx_pxl,
    output logic [4:0]             red,
    output logic [4:0]             green,
    output logic [4:0]             blue
);

    logic [PXLW-1:0] win_pxl;
    logic [PXLW-1:0] idx;
    logic [PXLW:0]   vid_addr;
    logic [7:0]      vid_q;
    logic [7:0]      cpu_q;
    logic [7:0]      first_byte;
    logic [15:0]     pend;
    logic            lhbl_l;
    logic            lvbl_l;
    logic            dout_ok;
    logic            pal_we;
    fetch_st_t       st;

    assign pal_we   = pal_cs & ~cpu_rnw & cpu_cen;
    assign pal_dout = dout_ok ? cpu_q : 8'd0;

    jtcontra_colmix_prio #(
        .LAYERS ( LAYERS ),
        .PXLW   ( PXLW   ),
        .BLKBIT ( BLKBIT )
    ) u_prio (
        .layer_en ( layer_en ),
        .gfx_pxl  ( gfx_pxl  ),
        .win_pxl  ( win_pxl  )
    );

    jtframe_dual_ram #(
        .dw ( 8      ),
        .aw ( PXLW+1 )
    ) u_pal (
        .clk0  ( clk      ),
        .data0 ( cpu_dout ),
        .addr0 ( cpu_addr ),
        .we0   ( pal_we   ),
        .q0    ( cpu_q    ),
        .clk1  ( clk      ),
        .addr1 ( vid_addr ),
        .q1    ( vid_q    )
    );

    // The RAM read register has no reset, so the CPU port is masked for the reset cycle.
    always_ff @(posedge clk) begin
        dout_ok <= ~rst;
    end

    // pxl_cen always wins over the fetch sequence; an early pulse restarts it and pend keeps its last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            idx        <= '0;
            vid_addr   <= '0;
            first_byte <= 8'd0;
            pend       <= 16'd0;
            lhbl_l     <= 1'b0;
            lvbl_l     <= 1'b0;
            LHBL_dly   <= 1'b0;
            LVBL_dly   <= 1'b0;
            red        <= 5'd0;
            green      <= 5'd0;
            blue       <= 5'd0;
        end else if (pxl_cen) begin
            idx                <= win_pxl;
            vid_addr           <= {win_pxl, 1'b0};
            st                 <= LO;
            {blue, green, red} <= (lhbl_l & lvbl_l) ? pend[14:0] : 15'd0;
            LHBL_dly           <= lhbl_l;
            LVBL_dly           <= lvbl_l;
            lhbl_l             <= LHBL;
            lvbl_l             <= LVBL;
        end else begin
            case (st)
                LO: begin
                    vid_addr <= {idx, 1'b1};
                    st       <= HI;
                end
                HI: begin
                    first_byte <= vid_q;
                    st         <= DONE;
                end
                DONE: begin
                    pend <= (HI_FIRST != 0) ? {first_byte, vid_q} : {vid_q, first_byte};
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcontra_prio_colmix.sv
// Randomized self-checking bench for jtcontra_prio_colmix against a pixel-level palette model.
module tb_jtcontra_prio_colmix;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic        LHBL, LVBL;
    logic        LHBL_dly, LVBL_dly;
    logic        pal_cs, cpu_rnw, cpu_cen;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  pal_dout;
    logic [1:0]  layer_en;
    logic [13:0] gfx_pxl;
    logic [4:0]  red, green, blue;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_pal [0:255];
    logic [14:0] m_pend;
    logic        m_hb, m_vb;

    jtcontra_prio_colmix dut (
        .clk      ( clk      ),
        .rst      ( rst      ),
        .pxl_cen  ( pxl_cen  ),
        .LHBL     ( LHBL     ),
        .LVBL     ( LVBL     ),
        .LHBL_dly ( LHBL_dly ),
        .LVBL_dly ( LVBL_dly ),
        .pal_cs   ( pal_cs   ),
        .cpu_rnw  ( cpu_rnw  ),
        .cpu_cen  ( cpu_cen  ),
        .cpu_addr ( cpu_addr ),
        .cpu_dout ( cpu_dout ),
        .pal_dout ( pal_dout ),
        .layer_en ( layer_en ),
        .gfx_pxl  ( gfx_pxl  ),
        .red      ( red      ),
        .green    ( green    ),
        .blue     ( blue     )
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Highest-priority opaque layer; layer 1 is also hidden by its blocking bit.
    function automatic logic [6:0] modelWinner(input logic [6:0] l0, input logic [6:0] l1,
                                               input logic [1:0] en);
        if (en[0] && l0[3:0] != 4'd0) return l0;
        if (en[1] && l1[3:0] != 4'd0 && !l1[4]) return l1;
        return l0;
    endfunction

    function automatic logic [14:0] modelColour(input logic [6:0] idx);
        logic [15:0] word;
        word = {m_pal[{idx, 1'b0}], m_pal[{idx, 1'b1}]};
        return word[14:0];
    endfunction

    task automatic cpuWrite(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = a; cpu_dout = d;
        @(posedge clk);
        @(negedge clk);
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        m_pal[a] = d;
    endtask

    task automatic cpuRead(input logic [7:0] a);
        @(negedge clk);
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_cen = 1'b0; cpu_addr = a;
        @(posedge clk);
        @(negedge clk);
        checkOutput("pal_dout", {8'd0, pal_dout}, {8'd0, m_pal[a]});
        pal_cs = 1'b0;
    endtask

    // One pixel: pulse pxl_cen, check the previous pixel's result, then idle gap-1 clocks.
    // wr_phase 1 lands a CPU write in the LO cycle; 3 lands it once the fetch is done.
    task automatic applyStimulus(input logic [6:0] l0, input logic [6:0] l1, input logic [1:0] en,
                                 input logic hb, input logic vb, input int gap,
                                 input int wr_phase, input logic [7:0] wr_addr,
                                 input logic [7:0] wr_data);
        logic [14:0] exp_rgb;
        logic        exp_h, exp_v;
        logic [14:0] new_col;
        @(negedge clk);
        gfx_pxl = {l1, l0}; layer_en = en; LHBL = hb; LVBL = vb; pxl_cen = 1'b1;
        exp_rgb = (m_hb && m_vb) ? m_pend : 15'd0;
        exp_h   = m_hb;
        exp_v   = m_vb;
        new_col = modelColour(modelWinner(l0, l1, en));
        m_hb = hb;
        m_vb = vb;
        @(posedge clk);
        @(negedge clk);
        pxl_cen = 1'b0;
        checkOutput("rgb", {1'b0, blue, green, red}, {1'b0, exp_rgb});
        checkOutput("lhbl_dly", {15'd0, LHBL_dly}, {15'd0, exp_h});
        checkOutput("lvbl_dly", {15'd0, LVBL_dly}, {15'd0, exp_v});
        for (int j = 1; j < gap; j++) begin
            if (j == wr_phase) begin
                pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = wr_addr; cpu_dout = wr_data;
            end
            @(posedge clk);
            @(negedge clk);
            if (j == wr_phase) begin
                pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
                m_pal[wr_addr] = wr_data;
            end
        end
        if (gap >= 4) m_pend = new_col;
    endtask

    task automatic resetDuringHi(input logic [6:0] l0);
        @(negedge clk);
        gfx_pxl = {7'd0, l0}; layer_en = 2'b11; LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pxl_cen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_hi_rgb", {1'b0, blue, green, red}, 16'd0);
        checkOutput("rst_hi_lhbl", {15'd0, LHBL_dly}, 16'd0);
        checkOutput("rst_hi_lvbl", {15'd0, LVBL_dly}, 16'd0);
        checkOutput("rst_hi_dout", {8'd0, pal_dout}, 16'd0);
        m_pend = 15'd0;
        m_hb   = 1'b0;
        m_vb   = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [6:0] l0, l1;
        logic [1:0] en;
        int         gap, ph;
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0; cpu_addr = 8'd0; cpu_dout = 8'd0;
        layer_en = 2'b11; gfx_pxl = 14'd0;
        m_pend = 15'd0; m_hb = 1'b0; m_vb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rgb", {1'b0, blue, green, red}, 16'd0);
        checkOutput("reset_lhbl", {15'd0, LHBL_dly}, 16'd0);
        checkOutput("reset_lvbl", {15'd0, LVBL_dly}, 16'd0);
        checkOutput("reset_dout", {8'd0, pal_dout}, 16'd0);
        rst = 1'b0;

        for (int a = 0; a < 256; a++) cpuWrite(8'(a), 8'($urandom));
        cpuWrite(8'h0A, 8'h7C);
        cpuWrite(8'h0B, 8'h1F);
        cpuWrite(8'h46, 8'h12);
        cpuWrite(8'h47, 8'h34);
        for (int i = 0; i < 8; i++) cpuRead(8'($urandom));
        cpuRead(8'h0A);

        // Directed: basic colour, transparency, blocking bit, enables.
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h10, 7'h23, 2'b11, 1'b1, 1'b1, 5, 0, 8'd0, 8'd0);
        checkOutput("blue_31", {11'd0, blue}, 16'd31);
        checkOutput("green_0", {11'd0, green}, 16'd0);
        checkOutput("red_31", {11'd0, red}, 16'd31);
        applyStimulus(7'h10, 7'h33, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        checkOutput("layer1_0x46", {1'b0, blue, green, red}, 16'h1234);
        applyStimulus(7'h05, 7'h23, 2'b10, 1'b1, 1'b1, 6, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h23, 2'b00, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);

        // Blanking delay and recovery.
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b0, 1'b1, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b0, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);

        // CPU write colliding with the LO read: old value now, new value next pixel.
        applyStimulus(7'h21, 7'h00, 2'b11, 1'b1, 1'b1, 4, 1, 8'h42, 8'h55);
        applyStimulus(7'h21, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        cpuRead(8'h42);

        // Early pxl_cen: the aborted fetch leaves the previous word pending.
        applyStimulus(7'h21, 7'h00, 2'b11, 1'b1, 1'b1, 5, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 2, 0, 8'd0, 8'd0);
        applyStimulus(7'h13, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);

        resetDuringHi(7'h05);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h21, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);

        // Random pixels with occasional spacing violations and post-fetch palette writes.
        for (int i = 0; i < 300; i++) begin
            l0  = 7'($urandom);
            l1  = 7'($urandom);
            if ($urandom_range(0, 3) == 0) l0[3:0] = 4'd0;
            if ($urandom_range(0, 3) == 0) l1[3:0] = 4'd0;
            en  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            gap = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(4, 7));
            ph  = (gap >= 4 && $urandom_range(0, 2) == 0) ? 3 : 0;
            applyStimulus(l0, l1, en, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                          gap, ph, 8'($urandom), 8'($urandom));
        end
        applyStimulus(7'h05, 7'h00, 2'b11, 1'b1, 1'b1, 4, 0, 8'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtcontra_prio_colmix.md
# jtcontra_prio_colmix

Parametrised multi-layer colour mixer and palette lookup, successor to the two-layer 007593-style mixer. Picks one of `LAYERS` tile/sprite pixel indices by transparency and per-pixel blocking, then fetches the 15-bit BGR colour from an internal byte-wide palette RAM with a deterministic two-read sequence aligned to `pxl_cen`. Blanking is applied on output. Sits between the tilemap/object generators and the video output stage; the CPU owns the palette through a byte port.

## Interface
- `LAYERS`, 2: number of pixel inputs, 2..4; layer 0 has the highest priority.
- `PXLW`, 7: palette index width per layer; palette RAM holds 2^(PXLW+1) bytes.
- `BLKBIT`, 4: pixel bit that blocks layers ≥1 when set; must be < PXLW.
- `HI_FIRST`, 1: 1 = byte at even address holds colour bits 15:8; 0 = bits 7:0.

- `clk` in 1: sole clock, video and CPU side.
- `rst` in 1: synchronous, active-high reset.
- `pxl_cen` in 1: pixel clock enable; consecutive pulses ≥4 `clk` apart.
- `LHBL`, `LVBL` in 1: active-low blanking.
- `LHBL_dly`, `LVBL_dly` out 1: blanking delayed to match colour output.
- `pal_cs`, `cpu_rnw`, `cpu_cen` in 1: palette select, read/not-write, CPU enable.
- `cpu_addr` in PXLW+1: palette byte address.
- `cpu_dout` in 8: write data.
- `pal_dout` out 8: palette read data, 1-cycle latency.
- `layer_en` in LAYERS: per-layer enable; 0 = layer treated as transparent.
- `gfx_pxl` in LAYERS*PXLW: layer k at bits [k*PXLW +: PXLW].
- `red`, `green`, `blue` out 5 each: colour outputs.

## Operation
- Write happens when `pal_cs & ~cpu_rnw & cpu_cen`. A CPU write and a video read to the same address in one cycle returns the old data to video.
- Layer k is opaque when `layer_en[k]` is set and pixel bits [3:0] ≠ 0.
- For k ≥ 1, bit `BLKBIT` set forces the layer transparent.
- The winner is the lowest-numbered opaque layer. If no layer is opaque, layer 0's index is used (backdrop colour).
- FSM states are IDLE, LO, HI, DONE:
  - `pxl_cen` in any state latches the winner index into `idx`, goes to LO and drives RAM address {idx,0}.
  - LO: drive {idx,1` }, go to HI.
  - HI: capture the first byte, go to DONE.
  - DONE: capture the second byte, assemble the 16-bit word per `HI_FIRST` into `pend`, go to IDLE.
- On `pxl_cen`, outputs load `{blue,green,red} = pend[14:0]`, or 0 if the delayed blanking (below) is active. Bit 15 is ignored.
- On `pxl_cen`, `LHBL_dly`/`LVBL_dly` load the values of `LHBL`/`LVBL` captured at the previous `pxl_cen`.
- A `pxl_cen` arriving before DONE completes (spacing violation) restarts the fetch; `pend` keeps its last complete value.

## Timing
- Reset: `red`/`green`/`blue` = 0, `LHBL_dly`/`LVBL_dly` = 0, `pend` = 0, FSM = IDLE, `idx` = 0, `pal_dout` = 0.
- Reset mid-fetch aborts the fetch; the first post-reset `pxl_cen` outputs 0.
- Latency: pixel presented at `pxl_cen` N appears on the outputs at `pxl_cen` N+1. Blanking has the same delay.
- The colour word is ready 3 `clk` after `pxl_cen`.
- `pal_dout` is valid 1 `clk` after the address is applied, regardless of `cpu_cen`.

## Structure
- Package `jtcontra_colmix_pkg`: FSM state enum (IDLE, LO, HI, DONE) and a `TRANSP_MASK` = 4'hF constant.
- Sub-module `jtcontra_colmix_prio`: combinational winner select over `LAYERS`/`PXLW`/`BLKBIT`.
- Palette storage: existing `jtframe_dual_ram` (aw = PXLW+1), both ports on `clk`.

## Test plan
- Write bytes 0x7C, 0x1F at addresses 0x0A/0x0B (`HI_FIRST`=1); layer0 = 0x05, blanking inactive → next `pxl_cen` gives blue=31, green=0, red=31.
- Layer0 = 0x10 (transparent), layer1 = 0x23 (BLKBIT clear) → address 0x46/0x47 fetched. Same with layer1 = 0x33 → layer0 index 0x10 used.
- `layer_en`=2'b10 with layer0 opaque → layer1 wins. All layers disabled → layer0 index used.
- `LHBL`=0 at pxl N → outputs 0 and `LHBL_dly`=0 at pxl N+1; colour resumes one pixel after `LHBL` returns to 1.
- CPU write to the address being fetched in the LO cycle → output shows the old value; the following pixel shows the new value. `pal_dout` readback matches after 1 cycle.
- `rst` asserted during HI → all outputs 0, FSM IDLE. `pxl_cen` 2 clk apart → fetch restarts, previous `pend` is output.
